// File: rtl/slt_iter_cmp_if.sv
// Request/response bundle for the iterative magnitude comparator.
//   master : the requester (CPU control unit or bench)
//   slave  : the comparator
// Signals:
//   in_valid/in_ready   request handshake
//   a, b                operands
//   aluc                [0]=signed compare, [1]=MIN/MAX result instead of SLT
//   minmax_sel          0 -> min(a,b), 1 -> max(a,b) (MIN/MAX mode only)
//   out_valid/out_ready result handshake
//   r                   result word
//   equal/smaller/greater  compare flags (a relative to b)
//   busy                unit is not idle
interface slt_iter_cmp_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       aluc;
    logic             minmax_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             equal;
    logic             smaller;
    logic             greater;
    logic             busy;

    modport master (
        output in_valid, a, b, aluc, minmax_sel, out_ready,
        input  in_ready, out_valid, r, equal, smaller, greater, busy
    );

    modport slave (
        input  in_valid, a, b, aluc, minmax_sel, out_ready,
        output in_ready, out_valid, r, equal, smaller, greater, busy
    );
endinterface

// File: rtl/slt_iter_cmp.sv
// Multi-cycle magnitude comparator for the ALU/branch path.
// Produces SLT/SLTU results or signed/unsigned MIN/MAX selection by scanning
// the operands MSB-first, DIGIT bits per cycle, optionally stopping at the
// first differing digit.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slt_iter_cmp_if slave modport (request/response handshakes,
//          operands, result and flags)
module slt_iter_cmp #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    slt_iter_cmp_if.slave bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("slt_iter_cmp: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;

    // Operand latches: originals for the MIN/MAX result, biased copies that
    // shift left one digit per cycle so the digit under test is always on top.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             mm_q;
    logic             sel_q;

    logic [CNT_W-1:0] cnt;
    logic             found;
    logic             rec_lt;

    logic [WIDTH-1:0] r_q;
    logic             equal_q;
    logic             smaller_q;
    logic             greater_q;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic             diff;
    logic             dlt;
    logic             finish;
    logic             fin_found;
    logic             fin_lt;
    logic             fin_sm;
    logic             fin_gt;
    logic [WIDTH-1:0] r_nxt;
    logic             accept;

    assign accept = (state == IDLE) && bus.in_valid;

    // Current digit compare
    assign da   = sa_q[WIDTH-1 -: DIGIT];
    assign db   = sb_q[WIDTH-1 -: DIGIT];
    assign diff = (da != db);
    assign dlt  = (da < db);

    assign finish = (cnt == LAST_DIGIT) || ((EARLY_EXIT != 0) && diff);

    // The earliest difference decides the outcome; a previously recorded one
    // takes priority over whatever the current digit shows.
    assign fin_found = found || diff;
    assign fin_lt    = found ? rec_lt : dlt;
    assign fin_sm    = fin_found && fin_lt;
    assign fin_gt    = fin_found && !fin_lt;

    // Equal operands fall through to a for both MIN and MAX.
    always_comb begin
        r_nxt = a_q;
        if (!mm_q) begin
            r_nxt = {{(WIDTH-1){1'b0}}, fin_sm};
        end else if (!sel_q) begin
            r_nxt = fin_gt ? b_q : a_q;
        end else begin
            r_nxt = fin_sm ? b_q : a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (finish)       state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and digit shift
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sa_q  <= bus.a ^ (bus.aluc[0] ? SIGN_MASK : '0);
            sb_q  <= bus.b ^ (bus.aluc[0] ? SIGN_MASK : '0);
            mm_q  <= bus.aluc[1];
            sel_q <= bus.minmax_sel;
        end else if (state == RUN) begin
            sa_q <= sa_q << DIGIT;
            sb_q <= sb_q << DIGIT;
        end
    end

    // Scan progress and result registers; results load only on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            found     <= 1'b0;
            rec_lt    <= 1'b0;
            r_q       <= '0;
            equal_q   <= 1'b0;
            smaller_q <= 1'b0;
            greater_q <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            found  <= 1'b0;
            rec_lt <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            if (!found && diff) begin
                found  <= 1'b1;
                rec_lt <= dlt;
            end
            if (finish) begin
                r_q       <= r_nxt;
                equal_q   <= !fin_found;
                smaller_q <= fin_sm;
                greater_q <= fin_gt;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.r         = r_q;
    assign bus.equal     = equal_q;
    assign bus.smaller   = smaller_q;
    assign bus.greater   = greater_q;
endmodule

// File: tb/tb_slt_iter_cmp.sv
// Directed bench for slt_iter_cmp: one DUT with early exit, one without.
module tb_slt_iter_cmp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    slt_iter_cmp_if #(.WIDTH(32)) if_e ();
    slt_iter_cmp_if #(.WIDTH(32)) if_f ();

    slt_iter_cmp #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(if_e.slave)
    );
    slt_iter_cmp #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .bus(if_f.slave)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request and wait for out_valid; returns latency in edges after accept.
    task automatic run_op(input bit use_f, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] aluc, input logic sel,
                          output int lat, output logic [31:0] r,
                          output logic eq, output logic sm, output logic gt);
        logic ov;
        @(negedge clk);
        if (use_f) begin
            if_f.in_valid = 1'b1; if_f.a = a; if_f.b = b; if_f.aluc = aluc; if_f.minmax_sel = sel;
        end else begin
            if_e.in_valid = 1'b1; if_e.a = a; if_e.b = b; if_e.aluc = aluc; if_e.minmax_sel = sel;
        end
        @(negedge clk);
        if (use_f) begin
            if_f.in_valid = 1'b0; if_f.a = ~a; if_f.b = ~b; if_f.minmax_sel = ~sel;
        end else begin
            if_e.in_valid = 1'b0; if_e.a = ~a; if_e.b = ~b; if_e.minmax_sel = ~sel;
        end
        lat = 0;
        ov = use_f ? if_f.out_valid : if_e.out_valid;
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
            ov = use_f ? if_f.out_valid : if_e.out_valid;
        end
        r  = use_f ? if_f.r       : if_e.r;
        eq = use_f ? if_f.equal   : if_e.equal;
        sm = use_f ? if_f.smaller : if_e.smaller;
        gt = use_f ? if_f.greater : if_e.greater;
    endtask

    task automatic take_result(input bit use_f);
        if (use_f) if_f.out_ready = 1'b1; else if_e.out_ready = 1'b1;
        @(negedge clk);
        if (use_f) if_f.out_ready = 1'b0; else if_e.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (if_e.out_valid !== 1'b0 || if_e.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b, want 0 0", if_e.out_valid, if_e.busy);
        end
        tests_run++;
        if (if_e.r !== 32'h0 || {if_e.equal, if_e.smaller, if_e.greater} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_data: r=%h flags=%b, want 0 000", if_e.r,
                     {if_e.equal, if_e.smaller, if_e.greater});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if_e.in_ready !== 1'b1 || if_f.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: e=%b f=%b, want 1", if_e.in_ready, if_f.in_ready);
        end
    endtask

    task automatic test_slt_unsigned();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h1 || {eq, sm, gt} !== 3'b010 || lat !== 1) begin
            tests_failed++;
            $display("FAIL sltu: r=%h flags=%b lat=%0d, want 00000001 010 1", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
    endtask

    task automatic test_slt_signed();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b01, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h0 || {eq, sm, gt} !== 3'b001 || lat !== 1) begin
            tests_failed++;
            $display("FAIL slt: r=%h flags=%b lat=%0d, want 00000000 001 1", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
    endtask

    task automatic test_equal();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b0, 32'h1234_5678, 32'h1234_5678, 2'b01, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h0 || {eq, sm, gt} !== 3'b100 || lat !== 8) begin
            tests_failed++;
            $display("FAIL equal: r=%h flags=%b lat=%0d, want 00000000 100 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
    endtask

    task automatic test_exit_depth();
        int lat; logic [31:0] r; logic eq, sm, gt;
        // first difference in digit 2
        run_op(1'b0, 32'h1230_0000, 32'h1240_0000, 2'b00, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h1 || {eq, sm, gt} !== 3'b010 || lat !== 3) begin
            tests_failed++;
            $display("FAIL depth2: r=%h flags=%b lat=%0d, want 00000001 010 3", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
        // difference only in the last digit
        run_op(1'b0, 32'h1234_5679, 32'h1234_5678, 2'b00, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h0 || {eq, sm, gt} !== 3'b001 || lat !== 8) begin
            tests_failed++;
            $display("FAIL depth7: r=%h flags=%b lat=%0d, want 00000000 001 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
    endtask

    task automatic test_no_early_exit();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b1, 32'h1000_0000, 32'h0000_0000, 2'b00, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h0 || {eq, sm, gt} !== 3'b001 || lat !== 8) begin
            tests_failed++;
            $display("FAIL noexit: r=%h flags=%b lat=%0d, want 00000000 001 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b1);
        // later digits favour b; only the first difference may count
        run_op(1'b1, 32'h2000_0000, 32'h1FFF_FFFF, 2'b00, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h0 || {eq, sm, gt} !== 3'b001 || lat !== 8) begin
            tests_failed++;
            $display("FAIL noexit_first: r=%h flags=%b lat=%0d, want 00000000 001 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b1);
        run_op(1'b1, 32'hCAFE_0001, 32'hCAFE_0001, 2'b11, 1'b1, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'hCAFE_0001 || {eq, sm, gt} !== 3'b100 || lat !== 8) begin
            tests_failed++;
            $display("FAIL noexit_eq: r=%h flags=%b lat=%0d, want cafe0001 100 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b1);
    endtask

    task automatic test_minmax();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h8000_0000 || {eq, sm, gt} !== 3'b010 || lat !== 1) begin
            tests_failed++;
            $display("FAIL min_signed: r=%h flags=%b lat=%0d, want 80000000 010 1", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 1'b0, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h7FFF_FFFF || {eq, sm, gt} !== 3'b001 || lat !== 1) begin
            tests_failed++;
            $display("FAIL min_unsigned: r=%h flags=%b lat=%0d, want 7fffffff 001 1", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 1'b1, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h7FFF_FFFF) begin
            tests_failed++;
            $display("FAIL max_signed: r=%h, want 7fffffff", r);
        end
        take_result(1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 1'b1, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL max_unsigned: r=%h, want 80000000", r);
        end
        take_result(1'b0);
    endtask

    task automatic test_done_hold();
        int lat; logic [31:0] r; logic eq, sm, gt;
        int bad;
        run_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0, lat, r, eq, sm, gt);
        for (int i = 0; i < 5; i++) begin
            if_e.in_valid = 1'b1; if_e.a = 32'h0000_0055; if_e.b = 32'h0000_0055; if_e.aluc = 2'b10;
            @(negedge clk);
            tests_run++;
            if (if_e.out_valid !== 1'b1 || if_e.in_ready !== 1'b0 || if_e.r !== 32'h1 ||
                {if_e.equal, if_e.smaller, if_e.greater} !== 3'b010) begin
                tests_failed++;
                $display("FAIL hold_%0d: ov=%b ir=%b r=%h flags=%b, want 1 0 00000001 010", i,
                         if_e.out_valid, if_e.in_ready, if_e.r, {if_e.equal, if_e.smaller, if_e.greater});
            end
        end
        if_e.in_valid = 1'b0;
        take_result(1'b0);
        tests_run++;
        if (if_e.out_valid !== 1'b0 || if_e.in_ready !== 1'b1 || if_e.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: ov=%b ir=%b busy=%b, want 0 1 0",
                     if_e.out_valid, if_e.in_ready, if_e.busy);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_e.busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL hold_dropped: busy seen %0d cycles, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] r; logic eq, sm, gt;
        run_op(1'b0, 32'h0000_0005, 32'h0000_0003, 2'b10, 1'b1, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h5 || {eq, sm, gt} !== 3'b001 || lat !== 8) begin
            tests_failed++;
            $display("FAIL b2b_first: r=%h flags=%b lat=%0d, want 00000005 001 8", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
        run_op(1'b0, 32'hFFFF_FFFE, 32'h0000_0002, 2'b11, 1'b1, lat, r, eq, sm, gt);
        tests_run++;
        if (r !== 32'h2 || {eq, sm, gt} !== 3'b010 || lat !== 1) begin
            tests_failed++;
            $display("FAIL b2b_second: r=%h flags=%b lat=%0d, want 00000002 010 1", r, {eq, sm, gt}, lat);
        end
        take_result(1'b0);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        if_e.in_valid = 1'b1; if_e.a = 32'h1234_5678; if_e.b = 32'h1234_5678; if_e.aluc = 2'b01;
        @(negedge clk);
        if_e.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (if_e.busy !== 1'b0 || if_e.in_ready !== 1'b1 || if_e.out_valid !== 1'b0 || if_e.r !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b ir=%b ov=%b r=%h, want 0 1 0 00000000",
                     if_e.busy, if_e.in_ready, if_e.out_valid, if_e.r);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (if_e.out_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_result: out_valid seen %0d cycles, want 0", seen);
        end
    endtask

    initial begin
        if_e.in_valid = 1'b0; if_e.a = '0; if_e.b = '0; if_e.aluc = '0;
        if_e.minmax_sel = 1'b0; if_e.out_ready = 1'b0;
        if_f.in_valid = 1'b0; if_f.a = '0; if_f.b = '0; if_f.aluc = '0;
        if_f.minmax_sel = 1'b0; if_f.out_ready = 1'b0;
        test_reset();
        test_slt_unsigned();
        test_slt_signed();
        test_equal();
        test_exit_depth();
        test_no_early_exit();
        test_minmax();
        test_back_to_back();
        test_done_hold();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
